// File: rtl/index_y_controller.sv
// Index-Y sequencer: accepts one Y-register operation, optionally performs a memory access, then issues Y strobes and N/Z/C flag updates.
// Latency: register ops execute the cycle after accept; memory ops execute the cycle after mem_ack, or abort with error after MEM_TIMEOUT wait cycles.
// Backpressure: op_ready is high only while idle; op inputs are ignored otherwise, giving one register op per two cycles at best.
module index_y_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       fclk,
    input  logic       resb,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [2:0] op_code,
    input  logic [7:0] op_operand,
    input  logic [7:0] y_value,
    output logic       y_load,
    output logic [7:0] y_load_data,
    output logic       y_increment,
    output logic       y_decrement,
    output logic       mem_req,
    output logic       mem_rwb,
    output logic [7:0] mem_wdata,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic       flag_we,
    output logic       flag_c_we,
    output logic       flag_n,
    output logic       flag_z,
    output logic       flag_c,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        EXEC = 2'd2
    } state_t;

    localparam logic [2:0] OP_LDY_IMM = 3'd0;
    localparam logic [2:0] OP_LDY_MEM = 3'd1;
    localparam logic [2:0] OP_STY     = 3'd2;
    localparam logic [2:0] OP_INY     = 3'd3;
    localparam logic [2:0] OP_DEY     = 3'd4;
    localparam logic [2:0] OP_CPY_IMM = 3'd5;
    localparam logic [2:0] OP_CPY_MEM = 3'd6;

    // Nine bits so that wait_cnt + 1 never wraps when compared with the limit.
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] code_q;
    logic [7:0] operand_q;
    logic [7:0] wdata_q;
    logic [7:0] wait_cnt;
    logic       abort_q;

    logic       accept;
    logic       op_is_mem;
    logic       timeout_hit;
    logic [7:0] inc_res;
    logic [7:0] dec_res;
    logic [7:0] cmp_diff;

    assign accept      = op_valid && op_ready;
    assign op_is_mem   = (op_code == OP_LDY_MEM) || (op_code == OP_STY) || (op_code == OP_CPY_MEM);
    // The current MEM cycle is the last one allowed when the incremented count meets the limit.
    assign timeout_hit = ({1'b0, wait_cnt} + 9'd1) >= TIMEOUT_LIM;
    assign inc_res     = y_value + 8'd1;
    assign dec_res     = y_value - 8'd1;
    assign cmp_diff    = y_value - operand_q;

    // State register with synchronous active-low reset.
    always_ff @(posedge fclk) begin
        if (!resb) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection: mem ops detour through MEM, which exits on ack or on timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = op_is_mem ? MEM : EXEC;
                end
            end
            MEM: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operation capture, memory read-data capture and the MEM wait counter.
    always_ff @(posedge fclk) begin
        if (!resb) begin
            code_q    <= 3'd0;
            operand_q <= 8'd0;
            wdata_q   <= 8'd0;
            wait_cnt  <= 8'd0;
            abort_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        code_q    <= op_code;
                        operand_q <= op_operand;
                        wdata_q   <= y_value;
                        wait_cnt  <= 8'd0;
                        abort_q   <= 1'b0;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        operand_q <= mem_rdata;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (timeout_hit) begin
                            abort_q <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    abort_q <= 1'b0;
                end
                default: begin
                    abort_q <= 1'b0;
                end
            endcase
        end
    end

    // Output decode: memory handshake in MEM, strobes and flags only in a non-aborted EXEC.
    always_comb begin
        op_ready    = 1'b0;
        y_load      = 1'b0;
        y_load_data = 8'd0;
        y_increment = 1'b0;
        y_decrement = 1'b0;
        mem_req     = 1'b0;
        mem_rwb     = 1'b0;
        mem_wdata   = 8'd0;
        flag_we     = 1'b0;
        flag_c_we   = 1'b0;
        flag_n      = 1'b0;
        flag_z      = 1'b0;
        flag_c      = 1'b0;
        done        = 1'b0;
        error       = 1'b0;
        case (state)
            IDLE: begin
                op_ready = 1'b1;
            end
            MEM: begin
                mem_req   = 1'b1;
                mem_rwb   = (code_q != OP_STY);
                mem_wdata = wdata_q;
            end
            EXEC: begin
                done = 1'b1;
                if (abort_q) begin
                    error = 1'b1;
                end else begin
                    case (code_q)
                        OP_LDY_IMM, OP_LDY_MEM: begin
                            y_load      = 1'b1;
                            y_load_data = operand_q;
                            flag_we     = 1'b1;
                            flag_n      = operand_q[7];
                            flag_z      = (operand_q == 8'd0);
                        end
                        OP_INY: begin
                            y_increment = 1'b1;
                            flag_we     = 1'b1;
                            flag_n      = inc_res[7];
                            flag_z      = (inc_res == 8'd0);
                        end
                        OP_DEY: begin
                            y_decrement = 1'b1;
                            flag_we     = 1'b1;
                            flag_n      = dec_res[7];
                            flag_z      = (dec_res == 8'd0);
                        end
                        OP_CPY_IMM, OP_CPY_MEM: begin
                            flag_we   = 1'b1;
                            flag_c_we = 1'b1;
                            flag_n    = cmp_diff[7];
                            flag_z    = (y_value == operand_q);
                            flag_c    = (y_value >= operand_q);
                        end
                        default: begin
                            // STY and NOP only signal completion.
                        end
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_index_y_controller.sv
// Randomized scoreboard bench for index_y_controller with a reference model and a model Y register.
// Driver issues ops and plays the memory side; monitor pops expectations whenever done is seen.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_index_y_controller;

    localparam int TMO = 15;

    logic       fclk;
    logic       resb;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_code;
    logic [7:0] op_operand;
    logic [7:0] y_value;
    logic       y_load;
    logic [7:0] y_load_data;
    logic       y_increment;
    logic       y_decrement;
    logic       mem_req;
    logic       mem_rwb;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       flag_we;
    logic       flag_c_we;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       done;
    logic       error;

    index_y_controller #(.MEM_TIMEOUT(TMO)) dut (
        .fclk(fclk), .resb(resb), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_operand(op_operand), .y_value(y_value),
        .y_load(y_load), .y_load_data(y_load_data), .y_increment(y_increment),
        .y_decrement(y_decrement), .mem_req(mem_req), .mem_rwb(mem_rwb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .flag_we(flag_we), .flag_c_we(flag_c_we), .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c), .done(done), .error(error)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    typedef struct {
        bit         is_mem;
        bit         rwb;
        logic [7:0] wdata;
        int         mem_cycles;
        int         lat;
        logic [2:0] strobes;    // {load, inc, dec}
        logic [4:0] flags;      // {we, c_we, n, z, c}
        logic [7:0] load_data;
        bit         err;
        logic [7:0] new_y;
    } exp_t;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         mon_en = 1'b0;
    logic [7:0] y_reg = 8'd0;

    assign y_value = y_reg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Architectural behaviour of one op; delay is the MEM cycle carrying ack, 0 meaning no ack.
    function automatic exp_t model(input logic [2:0] code, input logic [7:0] opnd, input logic [7:0] y,
                                   input logic [7:0] rdata, input int delay);
        exp_t e;
        int   v;
        int   yi;
        int   r;
        e.is_mem = (code == 3'd1) || (code == 3'd2) || (code == 3'd6);
        e.rwb = (code != 3'd2);
        e.wdata = y;
        e.mem_cycles = 0;
        e.lat = 1;
        e.strobes = 3'b000;
        e.flags = 5'b00000;
        e.load_data = 8'd0;
        e.err = 1'b0;
        e.new_y = y;
        v = int'(opnd);
        yi = int'(y);
        if (e.is_mem) begin
            if (delay == 0) begin
                e.mem_cycles = TMO;
                e.lat = TMO + 1;
                e.err = 1'b1;
                return e;
            end
            e.mem_cycles = delay;
            e.lat = delay + 1;
            v = int'(rdata);
        end
        case (code)
            3'd0, 3'd1: begin
                e.strobes = 3'b100;
                e.load_data = 8'(v);
                e.flags = {1'b1, 1'b0, v >= 128, v == 0, 1'b0};
                e.new_y = 8'(v);
            end
            3'd3: begin
                r = (yi + 1) % 256;
                e.strobes = 3'b010;
                e.flags = {1'b1, 1'b0, r >= 128, r == 0, 1'b0};
                e.new_y = 8'(r);
            end
            3'd4: begin
                r = (yi + 255) % 256;
                e.strobes = 3'b001;
                e.flags = {1'b1, 1'b0, r >= 128, r == 0, 1'b0};
                e.new_y = 8'(r);
            end
            3'd5, 3'd6: begin
                r = (yi - v + 256) % 256;
                e.flags = {1'b1, 1'b1, r >= 128, yi == v, yi >= v};
            end
            default: begin
            end
        endcase
        return e;
    endfunction

    // Issue one op at a cycle start and play the memory side; returns once the controller is idle again.
    task automatic run_op(input logic [2:0] code, input logic [7:0] opnd, input int delay, input logic [7:0] rdata);
        exp_t e;
        int   guard;
        e = model(code, opnd, y_reg, rdata, delay);
        guard = 0;
        while (!op_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!op_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_wait: op_ready still 0 after 100 cycles, expected 1");
            return;
        end
        op_valid = 1'b1;
        op_code = code;
        op_operand = opnd;
        exp_q.push_back(e);
        tick();
        // Junk on the op inputs while busy must not be accepted.
        op_valid = 1'($urandom_range(0, 1));
        op_code = 3'($urandom);
        op_operand = 8'($urandom);
        if (e.is_mem) begin
            for (int k = 1; k <= delay; k++) begin
                mem_ack = (k == delay);
                mem_rdata = (k == delay) ? rdata : 8'($urandom);
                tick();
            end
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
        end
        guard = 0;
        while (!op_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!op_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_complete: op_ready still 0 after 100 cycles, expected 1");
        end
        op_valid = 1'b0;
        y_reg = e.new_y;
    endtask

    // Monitor: quiet-when-idle checks every cycle, memory handshake against the pending op, and a pop on done.
    int mem_cnt = 0;
    int lat_cnt = 0;
    bit in_op = 1'b0;
    bit chk_ready = 1'b0;
    always @(negedge fclk) begin
        exp_t e;
        if (!mon_en) begin
            mem_cnt = 0;
            lat_cnt = 0;
            in_op = 1'b0;
            chk_ready = 1'b0;
        end else begin
            if (!done) begin
                check("quiet_outside_exec",
                      {15'd0, y_load, y_increment, y_decrement, flag_we, flag_c_we, error,
                       flag_n, flag_z, flag_c, y_load_data}, 32'd0);
            end
            if (in_op) lat_cnt++;
            if (mem_req) begin
                mem_cnt++;
                if (exp_q.size() > 0) begin
                    check("mem_rwb", {31'd0, mem_rwb}, {31'd0, exp_q[0].rwb});
                    check("mem_wdata", {24'd0, mem_wdata}, {24'd0, exp_q[0].wdata});
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("y_strobes", {29'd0, y_load, y_increment, y_decrement}, {29'd0, e.strobes});
                    check("flags", {27'd0, flag_we, flag_c_we, flag_n, flag_z, flag_c}, {27'd0, e.flags});
                    check("y_load_data", {24'd0, y_load_data}, {24'd0, e.load_data});
                    check("error", {31'd0, error}, {31'd0, e.err});
                    check("mem_cycles", mem_cnt, e.mem_cycles);
                    check("latency", lat_cnt, e.lat);
                end
                mem_cnt = 0;
                in_op = 1'b0;
                chk_ready = 1'b1;
            end else if (chk_ready) begin
                check("ready_after_done", {31'd0, op_ready}, 32'd1);
                chk_ready = 1'b0;
            end
            if (op_valid && op_ready) begin
                in_op = 1'b1;
                lat_cnt = 0;
                mem_cnt = 0;
            end
        end
    end

    initial begin
        resb = 1'b0;
        op_valid = 1'b0;
        op_code = 3'd0;
        op_operand = 8'd0;
        mem_ack = 1'b0;
        mem_rdata = 8'd0;
        repeat (3) tick();
        resb = 1'b1;
        @(negedge fclk);
        check("reset_ready", {31'd0, op_ready}, 32'd1);
        check("reset_outputs",
              {7'd0, y_load, y_load_data, y_increment, y_decrement, mem_req, mem_rwb, mem_wdata,
               flag_we, flag_c_we, flag_n, flag_z, flag_c, done, error}, 32'd0);
        tick();
        mon_en = 1'b1;

        // Directed corner cases.
        run_op(3'd0, 8'hFF, 0, 8'h00);   // Y = FF
        run_op(3'd3, 8'h00, 0, 8'h00);   // INY wraps to 00, Z=1
        run_op(3'd4, 8'h00, 0, 8'h00);   // DEY from 00 -> FF, N=1
        run_op(3'd0, 8'h40, 0, 8'h00);   // Y = 40
        run_op(3'd5, 8'h41, 0, 8'h00);   // CPY 41: N=1 Z=0 C=0
        run_op(3'd5, 8'h40, 0, 8'h00);   // CPY 40: Z=1 C=1
        run_op(3'd1, 8'h00, 3, 8'h80);   // LDY_MEM, ack in third cycle
        run_op(3'd0, 8'h5A, 0, 8'h00);   // Y = 5A
        run_op(3'd2, 8'h00, 0, 8'h00);   // STY with no ack -> timeout
        run_op(3'd6, 8'h00, 1, 8'h5A);   // CPY_MEM equal, immediate ack
        run_op(3'd7, 8'h00, 0, 8'h00);   // NOP

        // Reset while waiting in MEM aborts silently.
        mon_en = 1'b0;
        op_valid = 1'b1;
        op_code = 3'd1;
        op_operand = 8'h11;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
        resb = 1'b0;
        tick();
        resb = 1'b1;
        @(negedge fclk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_done_err", {30'd0, done, error}, 32'd0);
        check("rst_strobes", {29'd0, y_load, y_increment, y_decrement}, 32'd0);
        check("rst_ready", {31'd0, op_ready}, 32'd1);
        tick();
        mon_en = 1'b1;

        // Randomized traffic, mostly back-to-back with occasional gaps.
        for (int i = 0; i < 250; i++) begin
            logic [2:0] c;
            int         d;
            c = 3'($urandom_range(0, 7));
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
            run_op(c, 8'($urandom), d, 8'($urandom));
        end

        repeat (4) tick();
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
